mod_index_counter: RTL and testbench

MOD_INDEX_COUNTER -- requirements
Module: ModIndexCounter

---
 rtl/mod_index_counter.sv | 167 ++++++++++++++++
 tb/tb_mod_index_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_index_counter.sv
// Bank of independent modular index counters sharing one programmable modulus.
// Each channel loads, advances or retreats by a shared step and flags modulus crossings.
module mod_index_counter #(
    parameter int unsigned NUM_CHANNEL      = 3,
    parameter int unsigned DATA_INDEX_WIDTH = 32,
    parameter int unsigned BIT_ON_TAILS     = 7,
    parameter int unsigned STEP_WIDTH       = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [BIT_ON_TAILS:0]                  mod_len_i,
    input  logic                                   mod_len_load_i,
    input  logic [NUM_CHANNEL-1:0]                 inc_i,
    input  logic [NUM_CHANNEL-1:0]                 dec_i,
    input  logic [STEP_WIDTH-1:0]                  step_i,
    input  logic [NUM_CHANNEL-1:0]                 load_i,
    input  logic [DATA_INDEX_WIDTH-1:0]            load_value_i,
    output logic [NUM_CHANNEL*DATA_INDEX_WIDTH-1:0] index_o,
    output logic [NUM_CHANNEL-1:0]                 wrap_o,
    output logic [NUM_CHANNEL-1:0]                 step_err_o,
    output logic                                   cfg_err_o,
    output logic [BIT_ON_TAILS:0]                  act_len_o
);

    localparam int unsigned DW = DATA_INDEX_WIDTH;
    localparam int unsigned IW = BIT_ON_TAILS;
    localparam int unsigned LW = BIT_ON_TAILS + 1;
    localparam int unsigned SW = BIT_ON_TAILS + 2;
    localparam int unsigned CW = (STEP_WIDTH > LW) ? STEP_WIDTH : LW;
    localparam int unsigned VW = (DW > LW) ? DW : LW;
    localparam logic [LW-1:0] LEN_MAX = LW'(2 ** BIT_ON_TAILS);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_REJECT,
        OP_INC,
        OP_DEC
    } op_e;

    logic [LW-1:0] act_len_q, act_len_d;
    logic          cfg_err_q, cfg_err_d;

    logic          cfg_apply;
    logic          cfg_bad;
    logic          step_zero;
    logic          step_bad;
    logic [SW-1:0] step_s;
    logic [SW-1:0] len_s;
    logic [IW-1:0] load_idx;

    // A legal modulus request resets the whole bank; an illegal one only raises the sticky flag.
    assign cfg_apply = mod_len_load_i && (mod_len_i != '0) && (mod_len_i <= LEN_MAX);
    assign cfg_bad   = mod_len_load_i && !cfg_apply;

    assign step_zero = (step_i == '0);
    assign step_bad  = (CW'(step_i) >= CW'(act_len_q));
    assign step_s    = SW'(step_i);
    assign len_s     = SW'(act_len_q);
    assign load_idx  = (VW'(load_value_i) < VW'(act_len_q)) ? IW'(load_value_i) : '0;

    always_comb begin
        act_len_d = act_len_q;
        cfg_err_d = cfg_err_q | cfg_bad;
        if (cfg_apply) begin
            act_len_d = mod_len_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            act_len_q <= LEN_MAX;
            cfg_err_q <= 1'b0;
        end else begin
            act_len_q <= act_len_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign act_len_o = act_len_q;
    assign cfg_err_o = cfg_err_q;

    for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
        logic [IW-1:0] idx_q, idx_d;
        logic          wrap_q, wrap_d;
        logic          serr_q, serr_d;
        logic [SW-1:0] idx_s;
        logic [SW-1:0] inc_sum;
        logic [SW-1:0] dec_wrap_sum;
        logic          inc_over;
        logic          dec_under;
        op_e           op;

        // Sums are one bit wider than the modulus so idx+step never overflows.
        assign idx_s        = SW'(idx_q);
        assign inc_sum      = idx_s + step_s;
        assign inc_over     = (inc_sum >= len_s);
        assign dec_under    = (idx_s < step_s);
        assign dec_wrap_sum = idx_s + len_s - step_s;

        // Channel request priority: load, then inc+dec cancel, then inc, then dec.
        always_comb begin
            op = OP_HOLD;
            if (load_i[c]) begin
                op = OP_LOAD;
            end else if (inc_i[c] && dec_i[c]) begin
                op = OP_HOLD;
            end else if (inc_i[c] || dec_i[c]) begin
                if (step_zero) begin
                    op = OP_HOLD;
                end else if (step_bad) begin
                    op = OP_REJECT;
                end else if (inc_i[c]) begin
                    op = OP_INC;
                end else begin
                    op = OP_DEC;
                end
            end
        end

        always_comb begin
            idx_d  = idx_q;
            wrap_d = 1'b0;
            serr_d = 1'b0;
            if (cfg_apply) begin
                idx_d = '0;
            end else begin
                case (op)
                    OP_LOAD: begin
                        idx_d = load_idx;
                    end
                    OP_REJECT: begin
                        serr_d = 1'b1;
                    end
                    OP_INC: begin
                        idx_d  = inc_over ? IW'(inc_sum - len_s) : IW'(inc_sum);
                        wrap_d = inc_over;
                    end
                    OP_DEC: begin
                        idx_d  = dec_under ? IW'(dec_wrap_sum) : IW'(idx_s - step_s);
                        wrap_d = dec_under;
                    end
                    default: begin
                        idx_d = idx_q;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                idx_q  <= '0;
                wrap_q <= 1'b0;
                serr_q <= 1'b0;
            end else begin
                idx_q  <= idx_d;
                wrap_q <= wrap_d;
                serr_q <= serr_d;
            end
        end

        assign index_o[c*DW +: DW] = DW'(idx_q);
        assign wrap_o[c]           = wrap_q;
        assign step_err_o[c]       = serr_q;
    end

endmodule

// File: tb/tb_mod_index_counter.sv
// Self-checking bench for mod_index_counter: directed vector table plus a randomized
// phase checked against an arithmetic reference model through an expectation queue.
module tb_mod_index_counter;

    localparam int unsigned NCH = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned BT  = 7;
    localparam int unsigned STW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [BT:0]       mod_len;
    logic              mod_len_load;
    logic [NCH-1:0]    inc, dec, load;
    logic [STW-1:0]    step;
    logic [DW-1:0]     load_value;
    logic [NCH*DW-1:0] index;
    logic [NCH-1:0]    wrap, step_err;
    logic              cfg_err;
    logic [BT:0]       act_len;

    always #5 clk = ~clk;

    mod_index_counter #(
        .NUM_CHANNEL(NCH), .DATA_INDEX_WIDTH(DW), .BIT_ON_TAILS(BT), .STEP_WIDTH(STW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .mod_len_i(mod_len), .mod_len_load_i(mod_len_load),
        .inc_i(inc), .dec_i(dec), .step_i(step), .load_i(load), .load_value_i(load_value),
        .index_o(index), .wrap_o(wrap), .step_err_o(step_err), .cfg_err_o(cfg_err),
        .act_len_o(act_len)
    );

    typedef struct {
        logic        rst_n;
        logic        mll;
        logic [7:0]  ml;
        logic [2:0]  inc;
        logic [2:0]  dec;
        logic [2:0]  load;
        logic [3:0]  step;
        logic [31:0] lv;
    } stim_t;

    typedef struct {
        logic [31:0] idx [3];
        logic [2:0]  wrap;
        logic [2:0]  serr;
        logic        cfg;
        logic [7:0]  len;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int   m_len;
    int   m_idx [3];
    logic m_cfg;

    function automatic void add(input logic r, input logic mll, input logic [7:0] ml,
                                input logic [2:0] i, input logic [2:0] d, input logic [2:0] l,
                                input logic [3:0] st, input logic [31:0] lv,
                                input int e0, input int e1, input int e2,
                                input logic [2:0] w, input logic [2:0] se,
                                input logic cf, input logic [7:0] ln);
        vec_t v;
        v.s.rst_n = r; v.s.mll = mll; v.s.ml = ml; v.s.inc = i; v.s.dec = d;
        v.s.load = l; v.s.step = st; v.s.lv = lv;
        v.e.idx[0] = 32'(e0); v.e.idx[1] = 32'(e1); v.e.idx[2] = 32'(e2);
        v.e.wrap = w; v.e.serr = se; v.e.cfg = cf; v.e.len = ln;
        tbl.push_back(v);
    endfunction

    // Reference model: plain modular arithmetic on integers.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        e.wrap = '0;
        e.serr = '0;
        if (!s.rst_n) begin
            m_len = 128; m_cfg = 1'b0;
            for (int c = 0; c < 3; c++) m_idx[c] = 0;
        end else if (s.mll && s.ml >= 8'd1 && s.ml <= 8'd128) begin
            m_len = int'(s.ml);
            for (int c = 0; c < 3; c++) m_idx[c] = 0;
        end else begin
            if (s.mll) m_cfg = 1'b1;
            for (int c = 0; c < 3; c++) begin
                int st;
                st = int'(s.step);
                if (s.load[c]) begin
                    m_idx[c] = (s.lv < 32'(m_len)) ? int'(s.lv) : 0;
                end else if (s.inc[c] && s.dec[c]) begin
                    m_idx[c] = m_idx[c];
                end else if (s.inc[c] || s.dec[c]) begin
                    if (st == 0) begin
                        m_idx[c] = m_idx[c];
                    end else if (st >= m_len) begin
                        e.serr[c] = 1'b1;
                    end else if (s.inc[c]) begin
                        e.wrap[c] = (m_idx[c] + st) >= m_len;
                        m_idx[c]  = (m_idx[c] + st) % m_len;
                    end else begin
                        e.wrap[c] = m_idx[c] < st;
                        m_idx[c]  = (m_idx[c] - st + m_len) % m_len;
                    end
                end
            end
        end
        for (int c = 0; c < 3; c++) e.idx[c] = 32'(m_idx[c]);
        e.cfg = m_cfg;
        e.len = 8'(m_len);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input string tag, input stim_t s, input exp_t e);
        exp_t got;
        @(negedge clk);
        rst_n = s.rst_n; mod_len_load = s.mll; mod_len = s.ml;
        inc = s.inc; dec = s.dec; load = s.load; step = s.step; load_value = s.lv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = exp_q.pop_front();
            for (int c = 0; c < 3; c++)
                check($sformatf("%s idx%0d", tag, c), index[c*DW +: DW], got.idx[c]);
            check({tag, " wrap"},    32'(wrap),     32'(got.wrap));
            check({tag, " steperr"}, 32'(step_err), 32'(got.serr));
            check({tag, " cfgerr"},  32'(cfg_err),  32'(got.cfg));
            check({tag, " actlen"},  32'(act_len),  32'(got.len));
        end
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        rst_n = 1'b0; mod_len_load = 1'b0; mod_len = '0; inc = '0; dec = '0;
        load = '0; step = '0; load_value = '0;

        //   rst mll ml    inc     dec     load    st  lv   | i0  i1  i2  wrap    serr    cfg len
        add(0, 0, 0,   3'b000, 3'b000, 3'b000, 0,  0,     0,  0,  0,  3'b000, 3'b000, 0, 128);
        add(1, 0, 0,   3'b000, 3'b000, 3'b001, 0,  126, 126,  0,  0,  3'b000, 3'b000, 0, 128);
        add(1, 0, 0,   3'b001, 3'b000, 3'b000, 1,  0,   127,  0,  0,  3'b000, 3'b000, 0, 128);
        add(1, 0, 0,   3'b001, 3'b000, 3'b000, 1,  0,     0,  0,  0,  3'b001, 3'b000, 0, 128);
        add(1, 0, 0,   3'b000, 3'b010, 3'b000, 3,  0,     0, 125, 0,  3'b010, 3'b000, 0, 128);
        add(1, 0, 0,   3'b000, 3'b000, 3'b100, 0,  50,    0, 125, 50, 3'b000, 3'b000, 0, 128);
        add(1, 1, 10,  3'b100, 3'b000, 3'b000, 4,  0,     0,  0,  0,  3'b000, 3'b000, 0, 10);
        add(1, 0, 0,   3'b100, 3'b000, 3'b000, 4,  0,     0,  0,  4,  3'b000, 3'b000, 0, 10);
        add(1, 0, 0,   3'b100, 3'b000, 3'b000, 4,  0,     0,  0,  8,  3'b000, 3'b000, 0, 10);
        add(1, 0, 0,   3'b100, 3'b000, 3'b000, 4,  0,     0,  0,  2,  3'b100, 3'b000, 0, 10);
        add(1, 0, 0,   3'b011, 3'b010, 3'b000, 12, 0,     0,  0,  2,  3'b000, 3'b001, 0, 10);
        add(1, 0, 0,   3'b010, 3'b000, 3'b000, 10, 0,     0,  0,  2,  3'b000, 3'b010, 0, 10);
        add(1, 0, 0,   3'b000, 3'b001, 3'b000, 0,  0,     0,  0,  2,  3'b000, 3'b000, 0, 10);
        add(1, 1, 0,   3'b000, 3'b000, 3'b001, 0,  7,     7,  0,  2,  3'b000, 3'b000, 1, 10);
        add(1, 1, 128, 3'b000, 3'b000, 3'b000, 0,  0,     0,  0,  0,  3'b000, 3'b000, 1, 128);
        add(1, 1, 200, 3'b000, 3'b000, 3'b000, 0,  0,     0,  0,  0,  3'b000, 3'b000, 1, 128);
        add(1, 0, 0,   3'b000, 3'b000, 3'b001, 0,  200,   0,  0,  0,  3'b000, 3'b000, 1, 128);
        add(1, 0, 0,   3'b000, 3'b000, 3'b010, 0,  127,   0, 127, 0,  3'b000, 3'b000, 1, 128);
        add(1, 0, 0,   3'b001, 3'b110, 3'b000, 5,  0,     5, 122, 123, 3'b100, 3'b000, 1, 128);
        add(1, 1, 1,   3'b111, 3'b000, 3'b000, 1,  0,     0,  0,  0,  3'b000, 3'b000, 1, 1);
        add(1, 0, 0,   3'b111, 3'b000, 3'b000, 1,  0,     0,  0,  0,  3'b000, 3'b111, 1, 1);
        add(1, 0, 0,   3'b000, 3'b111, 3'b000, 0,  0,     0,  0,  0,  3'b000, 3'b000, 1, 1);
        add(1, 1, 129, 3'b000, 3'b000, 3'b000, 0,  0,     0,  0,  0,  3'b000, 3'b000, 1, 1);
        add(1, 1, 128, 3'b000, 3'b000, 3'b000, 0,  0,     0,  0,  0,  3'b000, 3'b000, 1, 128);
        add(1, 0, 0,   3'b000, 3'b000, 3'b111, 0,  60,   60, 60, 60,  3'b000, 3'b000, 1, 128);
        add(0, 1, 5,   3'b111, 3'b000, 3'b111, 3,  9,     0,  0,  0,  3'b000, 3'b000, 0, 128);
        add(1, 0, 0,   3'b111, 3'b000, 3'b000, 3,  0,     3,  3,  3,  3'b000, 3'b000, 0, 128);
        add(1, 0, 0,   3'b000, 3'b111, 3'b010, 3,  128,   0,  0,  0,  3'b000, 3'b000, 0, 128);
        add(1, 0, 0,   3'b000, 3'b101, 3'b000, 1,  0,   127,  0, 127, 3'b101, 3'b000, 0, 128);
        add(1, 0, 0,   3'b001, 3'b000, 3'b000, 15, 0,    14,  0, 127, 3'b001, 3'b000, 0, 128);

        foreach (tbl[k]) begin
            e = model(tbl[k].s);
            apply($sformatf("vec%0d", k), tbl[k].s, tbl[k].e);
        end

        // Randomized traffic against the reference model, starting from reset.
        for (int k = 0; k < 400; k++) begin
            int r;
            s.rst_n = (k == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            s.mll   = ($urandom_range(0, 14) == 0);
            r = $urandom_range(0, 9);
            s.ml    = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(129, 255))
                    : (r < 5) ? 8'($urandom_range(1, 16)) : 8'($urandom_range(1, 128));
            s.inc   = 3'($urandom);
            s.dec   = 3'($urandom);
            s.load  = 3'($urandom) & 3'($urandom) & 3'($urandom);
            s.step  = 4'($urandom);
            s.lv    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 140));
            e = model(s);
            apply($sformatf("rnd%0d", k), s, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
